// File: rtl/uart_bus_responder_if.sv
// Strobe/status handshake between the CPU-side memory/UART controller and the UART responder.
interface uart_bus_responder_if;
  logic rdn;
  logic wrn;
  logic data_ready;
  logic tbre;
  logic tsre;

  modport master (output rdn, output wrn, input data_ready, input tbre, input tsre);
  modport slave  (input rdn, input wrn, output data_ready, output tbre, output tsre);
endinterface

// File: rtl/uart_bus_responder.sv
// Bus-side model of the board UART chip: answers rdn/wrn on the shared data bus,
// serializes written bytes onto txd and deserializes 8N1 frames from rxd.
module uart_bus_responder #(
  parameter int unsigned CLK_DIV = 96
) (
  input  logic                clk,
  input  logic                rst,
  inout  wire  [15:0]         data,
  uart_bus_responder_if.slave bus,
  output logic                txd,
  input  logic                rxd,
  output logic                tx_overrun,
  output logic                rx_overrun,
  output logic                rx_frame_err
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} phase_t;

  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] MID  = 16'(CLK_DIV / 2);

  logic       rdn_d, wrn_d;
  logic       write_strobe, read_release;
  logic       unused_hi;

  phase_t     tx_state_reg, tx_state_next;
  logic [15:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0] tx_bit_reg, tx_bit_next;
  logic [7:0] tx_shift_reg, tx_shift_next;
  logic [7:0] thr_reg, thr_next;
  logic       txd_reg, txd_next;
  logic       tbre_reg, tbre_next;
  logic       tsre_reg, tsre_next;
  logic       tx_overrun_reg, tx_overrun_next;

  logic       rx_s1_reg, rx_s2_reg;
  phase_t     rx_state_reg, rx_state_next;
  logic [15:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0] rx_bit_reg, rx_bit_next;
  logic [7:0] rx_shift_reg, rx_shift_next;
  logic [7:0] rhr_reg, rhr_next;
  logic       data_ready_reg, data_ready_next;
  logic       rx_overrun_reg, rx_overrun_next;
  logic       rx_frame_err_reg, rx_frame_err_next;

  assign write_strobe = ~bus.wrn & wrn_d;
  assign read_release = bus.rdn & ~rdn_d;
  assign unused_hi    = ^data[15:8];

  // The bus is driven combinationally for as long as the read strobe is low.
  assign data = bus.rdn ? 16'hzzzz : {8'h00, rhr_reg};

  assign txd            = txd_reg;
  assign bus.tbre       = tbre_reg;
  assign bus.tsre       = tsre_reg;
  assign bus.data_ready = data_ready_reg;
  assign tx_overrun     = tx_overrun_reg;
  assign rx_overrun     = rx_overrun_reg;
  assign rx_frame_err   = rx_frame_err_reg;

  always_comb begin
    thr_next        = thr_reg;
    tbre_next       = tbre_reg;
    tsre_next       = tsre_reg;
    tx_state_next   = tx_state_reg;
    tx_cnt_next     = tx_cnt_reg + 16'd1;
    tx_bit_next     = tx_bit_reg;
    tx_shift_next   = tx_shift_reg;
    txd_next        = txd_reg;
    tx_overrun_next = tx_overrun_reg;

    if (write_strobe) begin
      if (tbre_reg) begin
        thr_next  = data[7:0];
        tbre_next = 1'b0;
      end else begin
        tx_overrun_next = 1'b1;
      end
    end

    unique case (tx_state_reg)
      IDLE: begin
        tx_cnt_next = '0;
        if (!tbre_reg) begin
          tx_shift_next = thr_reg;
          tbre_next     = 1'b1;
          tsre_next     = 1'b0;
          txd_next      = 1'b0;
          tx_state_next = START;
        end
      end
      START: begin
        if (tx_cnt_reg == LAST) begin
          tx_cnt_next   = '0;
          tx_bit_next   = '0;
          txd_next      = tx_shift_reg[0];
          tx_state_next = DATA;
        end
      end
      DATA: begin
        if (tx_cnt_reg == LAST) begin
          tx_cnt_next = '0;
          if (tx_bit_reg == 3'd7) begin
            txd_next      = 1'b1;
            tx_state_next = STOP;
          end else begin
            tx_bit_next   = tx_bit_reg + 3'd1;
            tx_shift_next = {1'b1, tx_shift_reg[7:1]};
            txd_next      = tx_shift_reg[1];
          end
        end
      end
      STOP: begin
        if (tx_cnt_reg == LAST) begin
          tx_cnt_next = '0;
          // A byte already waiting in THR chains straight into the next start bit.
          if (!tbre_reg) begin
            tx_shift_next = thr_reg;
            tbre_next     = 1'b1;
            txd_next      = 1'b0;
            tx_state_next = START;
          end else begin
            tsre_next     = 1'b1;
            tx_state_next = IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    rx_state_next     = rx_state_reg;
    rx_cnt_next       = rx_cnt_reg + 16'd1;
    rx_bit_next       = rx_bit_reg;
    rx_shift_next     = rx_shift_reg;
    rhr_next          = rhr_reg;
    data_ready_next   = data_ready_reg;
    rx_overrun_next   = rx_overrun_reg;
    rx_frame_err_next = rx_frame_err_reg;

    if (read_release)
      data_ready_next = 1'b0;

    unique case (rx_state_reg)
      IDLE: begin
        // The detecting cycle counts as the first cycle of the start bit.
        rx_cnt_next = 16'd1;
        if (!rx_s2_reg)
          rx_state_next = START;
      end
      START: begin
        if (rx_cnt_reg == MID) begin
          rx_cnt_next   = '0;
          rx_bit_next   = '0;
          rx_state_next = rx_s2_reg ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_cnt_reg == LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_s2_reg, rx_shift_reg[7:1]};
          if (rx_bit_reg == 3'd7)
            rx_state_next = STOP;
          else
            rx_bit_next = rx_bit_reg + 3'd1;
        end
      end
      STOP: begin
        if (rx_cnt_reg == LAST) begin
          rx_state_next = IDLE;
          if (!rx_s2_reg) begin
            rx_frame_err_next = 1'b1;
          end else if (!data_ready_reg || read_release) begin
            rhr_next        = rx_shift_reg;
            data_ready_next = 1'b1;
          end else begin
            rx_overrun_next = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdn_d            <= 1'b1;
      wrn_d            <= 1'b1;
      tx_state_reg     <= IDLE;
      tx_cnt_reg       <= '0;
      tx_bit_reg       <= '0;
      tx_shift_reg     <= '0;
      thr_reg          <= '0;
      txd_reg          <= 1'b1;
      tbre_reg         <= 1'b1;
      tsre_reg         <= 1'b1;
      tx_overrun_reg   <= 1'b0;
      rx_s1_reg        <= 1'b1;
      rx_s2_reg        <= 1'b1;
      rx_state_reg     <= IDLE;
      rx_cnt_reg       <= '0;
      rx_bit_reg       <= '0;
      rx_shift_reg     <= '0;
      rhr_reg          <= '0;
      data_ready_reg   <= 1'b0;
      rx_overrun_reg   <= 1'b0;
      rx_frame_err_reg <= 1'b0;
    end else begin
      rdn_d            <= bus.rdn;
      wrn_d            <= bus.wrn;
      tx_state_reg     <= tx_state_next;
      tx_cnt_reg       <= tx_cnt_next;
      tx_bit_reg       <= tx_bit_next;
      tx_shift_reg     <= tx_shift_next;
      thr_reg          <= thr_next;
      txd_reg          <= txd_next;
      tbre_reg         <= tbre_next;
      tsre_reg         <= tsre_next;
      tx_overrun_reg   <= tx_overrun_next;
      rx_s1_reg        <= rxd;
      rx_s2_reg        <= rx_s1_reg;
      rx_state_reg     <= rx_state_next;
      rx_cnt_reg       <= rx_cnt_next;
      rx_bit_reg       <= rx_bit_next;
      rx_shift_reg     <= rx_shift_next;
      rhr_reg          <= rhr_next;
      data_ready_reg   <= data_ready_next;
      rx_overrun_reg   <= rx_overrun_next;
      rx_frame_err_reg <= rx_frame_err_next;
    end
  end
endmodule

// File: tb/tb_uart_bus_responder.sv
// Self-checking bench for uart_bus_responder: TX frames go through a serial scoreboard,
// RX, flags and bus reads are checked with hand-computed expectations.
module tb_uart_bus_responder;
  localparam int D = 8;
  localparam int H = D / 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [15:0] data;
  logic [15:0] data_drv = '0;
  logic        data_oe = 1'b0;
  logic        txd;
  logic        rxd_drv = 1'b1;
  logic        loopback = 1'b0;
  wire         rxd;
  logic        tx_overrun, rx_overrun, rx_frame_err;

  uart_bus_responder_if bus();

  assign data = data_oe ? data_drv : 16'hzzzz;
  assign rxd  = loopback ? txd : rxd_drv;

  uart_bus_responder #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .data(data), .bus(bus),
    .txd(txd), .rxd(rxd),
    .tx_overrun(tx_overrun), .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // TX scoreboard: bytes pushed at write time, popped when a full frame is seen on txd.
  logic [7:0] exp_q[$];
  int last_start = -1;
  int prev_start = -1;

  initial begin : tx_monitor
    int busy;
    int k;
    int start;
    logic [7:0] b;
    busy = 0; k = 0; start = 0; b = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0;
      end else if (busy == 0) begin
        if (txd === 1'b0) begin
          busy = 1; k = 0; start = cyc;
        end
      end else begin
        k = k + 1;
        if (k == H) begin
          check("tx_start_bit", {31'd0, txd}, 32'd0);
        end else if (k > H && k <= H + 8 * D && (k - H) % D == 0) begin
          b = {txd, b[7:1]};
        end else if (k == H + 9 * D) begin
          check("tx_stop_bit", {31'd0, txd}, 32'd1);
          if (exp_q.size() == 0) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL tx_unexpected_frame: got %02h expected no frame", b);
          end else begin
            check("tx_frame_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
          end
          $display("txd frame %02h started at cycle %0d", b, start);
          prev_start = last_start;
          last_start = start;
          busy = 0;
        end
      end
    end
  end

  int dr_rise = -1;
  initial begin : ready_monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.data_ready && !prev) dr_rise = cyc;
      prev = bus.data_ready;
    end
  end

  task automatic do_write(input logic [15:0] w, input bit chk, output int n);
    @(posedge clk); #1;
    data_drv = w; data_oe = 1'b1; bus.wrn = 1'b0; n = cyc;
    @(negedge clk);
    if (chk) check("tbre_at_strobe", {31'd0, bus.tbre}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    if (chk) check("tbre_low_n1", {31'd0, bus.tbre}, 32'd0);
    @(posedge clk); #1;
    bus.wrn = 1'b1; data_oe = 1'b0;
    @(negedge clk);
    if (chk) begin
      check("tbre_high_n2", {31'd0, bus.tbre}, 32'd1);
      check("tsre_low_n2", {31'd0, bus.tsre}, 32'd0);
    end
    $display("write %04h at cycle %0d", w, n);
  endtask

  task automatic wait_tsre(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (bus.tsre) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (at < 0) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL tsre_timeout: got 0 expected 1 within %0d cycles", budget);
    end
  endtask

  task automatic do_read(output logic [15:0] v, output int m);
    @(posedge clk); #1;
    bus.rdn = 1'b0;
    @(negedge clk);
    v = data;
    @(posedge clk); #1;
    bus.rdn = 1'b1; m = cyc;
    @(negedge clk);
    check("ready_during_release", {31'd0, bus.data_ready}, 32'd1);
    @(negedge clk);
    check("ready_after_release", {31'd0, bus.data_ready}, 32'd0);
    $display("read %04h released at cycle %0d", v, m);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb, output int f);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    @(posedge clk); #1;
    f = cyc;
    for (int i = 0; i < 10; i++) begin
      rxd_drv = fr[i];
      repeat (D) @(posedge clk);
      #1;
    end
    rxd_drv = 1'b1;
    $display("rxd frame %02h stop=%0b started at cycle %0d", b, stopb, f);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  typedef struct {
    logic [15:0] w;
    logic [7:0]  exp;
  } tx_vec_t;

  tx_vec_t tx_tab [4];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n, n1, n2, at, f, m, got;
    logic [15:0] v;

    tx_tab[0] = '{w: 16'hAB55, exp: 8'h55};
    tx_tab[1] = '{w: 16'hFF00, exp: 8'h00};
    tx_tab[2] = '{w: 16'h12FF, exp: 8'hFF};
    tx_tab[3] = '{w: 16'h00A6, exp: 8'hA6};

    bus.rdn = 1'b1;
    bus.wrn = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_tbre", {31'd0, bus.tbre}, 32'd1);
    check("rst_tsre", {31'd0, bus.tsre}, 32'd1);
    check("rst_ready", {31'd0, bus.data_ready}, 32'd0);
    check("rst_flags", {29'd0, tx_overrun, rx_overrun, rx_frame_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // Table-driven single writes
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(tx_tab[i].exp);
      do_write(tx_tab[i].w, 1'b1, n);
      wait_tsre(200, at);
      check("tsre_rise_cycle", at - n, 32'd82);
      repeat (5) @(posedge clk);
    end
    check("tx_queue_empty", exp_q.size(), 32'd0);

    // Back-to-back frames plus an overrun write
    exp_q.push_back(8'h31);
    do_write(16'h0031, 1'b1, n1);
    repeat (20) @(posedge clk);
    exp_q.push_back(8'h32);
    do_write(16'h0032, 1'b0, n2);
    check("tbre_held", {31'd0, bus.tbre}, 32'd0);
    do_write(16'h0033, 1'b0, n);
    check("tx_overrun_set", {31'd0, tx_overrun}, 32'd1);
    wait_tsre(400, at);
    check("b2b_total", at - n1, 32'd162);
    check("b2b_gap", last_start - prev_start, 32'd80);
    repeat (100) @(negedge clk);
    check("overrun_byte_dropped", exp_q.size(), 32'd0);

    pulse_reset();
    @(negedge clk);
    check("tx_overrun_cleared", {31'd0, tx_overrun}, 32'd0);

    // RX: good frame, latency and read
    send_frame(8'hC3, 1'b1, f);
    @(negedge clk);
    check("rx_latency", dr_rise - f, 32'd79);
    check("rx_ready", {31'd0, bus.data_ready}, 32'd1);
    do_read(v, m);
    check("rx_read_c3", {16'd0, v}, 32'h00C3);

    // Glitch must not disturb a waiting byte
    send_frame(8'h3C, 1'b1, f);
    @(posedge clk); #1;
    rxd_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rxd_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_ready", {31'd0, bus.data_ready}, 32'd1);
    check("glitch_flags", {30'd0, rx_overrun, rx_frame_err}, 32'd0);
    do_read(v, m);
    check("rx_read_3c", {16'd0, v}, 32'h003C);

    // Overrun then framing error, with the first byte still held
    send_frame(8'h11, 1'b1, f);
    send_frame(8'h22, 1'b1, f);
    repeat (4) @(negedge clk);
    check("rx_overrun_set", {31'd0, rx_overrun}, 32'd1);
    check("rx_frame_err_clear", {31'd0, rx_frame_err}, 32'd0);
    send_frame(8'h5A, 1'b0, f);
    repeat (40) @(negedge clk);
    check("rx_frame_err_set", {31'd0, rx_frame_err}, 32'd1);
    check("ferr_ready_kept", {31'd0, bus.data_ready}, 32'd1);
    do_read(v, m);
    check("rx_read_11", {16'd0, v}, 32'h0011);

    // Reset in the middle of a transmitted frame
    exp_q.push_back(8'h00);
    do_write(16'h0000, 1'b0, n);
    repeat (30) @(negedge clk);
    check("txd_mid_frame", {31'd0, txd}, 32'd0);
    rst = 1'b1;
    #1;
    check("txd_async_reset", {31'd0, txd}, 32'd1);
    check("tbre_async_reset", {31'd0, bus.tbre}, 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flags_after_reset", {29'd0, tx_overrun, rx_overrun, rx_frame_err}, 32'd0);

    // Loopback
    loopback = 1'b1;
    repeat (4) @(posedge clk);
    exp_q.push_back(8'h7E);
    do_write(16'h007E, 1'b1, n);
    got = 0;
    for (int i = 0; i < 200 && got == 0; i++) begin
      @(negedge clk);
      if (bus.data_ready) got = 1;
    end
    check("loop_ready", got, 32'd1);
    check("loop_latency", dr_rise - n, 32'd81);
    wait_tsre(200, at);
    exp_q.push_back(8'h81);
    do_write(16'h0081, 1'b1, n2);
    @(posedge clk); #1;
    bus.rdn = 1'b0;
    @(negedge clk);
    check("loop_read_7e", {16'd0, data}, 32'h007E);
    repeat (n2 + 80 - cyc) @(posedge clk);
    #1;
    bus.rdn = 1'b1;
    $display("read release at cycle %0d against stop sample of 0x81", cyc);
    repeat (2) @(negedge clk);
    check("simul_ready_kept", {31'd0, bus.data_ready}, 32'd1);
    check("simul_no_overrun", {31'd0, rx_overrun}, 32'd0);
    do_read(v, m);
    check("loop_read_81", {16'd0, v}, 32'h0081);
    wait_tsre(200, at);
    repeat (20) @(negedge clk);
    check("loop_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
